// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use and branch-in-ID RAW stalls,
// EXE operand forwarding select, and a fixed-latency MDU hold FSM. Define FORWARDING_EN for forwarding.
module pipeline_hazard_ctrl #(
  parameter int MDU_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_is_branch,
  input  logic       id_is_mdu,
  input  logic [4:0] ex_rs_addr,
  input  logic [4:0] ex_rt_addr,
  input  logic [4:0] ex_wr_addr,
  input  logic       ex_regwe,
  input  logic       ex_is_load,
  input  logic [4:0] mem_wr_addr,
  input  logic       mem_regwe,
  input  logic       mem_is_load,
  input  logic [4:0] wb_wr_addr,
  input  logic       wb_regwe,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_exe_pause,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       mdu_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [3:0] CNT_INIT = 4'(MDU_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mdu_stall;
  logic       data_haz;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;

  // Register $0 is hard-wired to zero, so it can never carry a dependency.
  function automatic logic src_hit(input logic [4:0] dst, input logic [4:0] src, input logic used);
    return used && (src != 5'd0) && (src == dst);
  endfunction

  logic ex_hit, mem_hit;
  assign ex_hit  = src_hit(ex_wr_addr,  id_rs_addr, id_rs_used) |
                   src_hit(ex_wr_addr,  id_rt_addr, id_rt_used);
  assign mem_hit = src_hit(mem_wr_addr, id_rs_addr, id_rs_used) |
                   src_hit(mem_wr_addr, id_rt_addr, id_rt_used);

`ifdef FORWARDING_EN
  logic load_use, br_haz;
  assign load_use = ex_is_load & ex_regwe & ex_hit;
  // A branch compares in ID, so it cannot take an EXE result and needs load data only after MEM.
  assign br_haz   = id_is_branch & ((ex_regwe & ex_hit) | (mem_is_load & mem_regwe & mem_hit));
  assign data_haz = load_use | br_haz;

  function automatic logic [1:0] fwd_pick(input logic [4:0] src, input logic [4:0] m_addr,
                                          input logic m_we, input logic [4:0] w_addr,
                                          input logic w_we);
    if (src == 5'd0)                return 2'd0;
    else if (m_we && m_addr == src) return 2'd1;
    else if (w_we && w_addr == src) return 2'd2;
    else                            return 2'd0;
  endfunction

  assign fwd_a = fwd_pick(ex_rs_addr, mem_wr_addr, mem_regwe, wb_wr_addr, wb_regwe);
  assign fwd_b = fwd_pick(ex_rt_addr, mem_wr_addr, mem_regwe, wb_wr_addr, wb_regwe);
`else
  // Without bypass paths every in-flight producer must retire to the regfile; WB writes in the
  // first half-cycle, so only EXE and MEM producers block.
  assign data_haz = (ex_regwe & ex_hit) | (mem_regwe & mem_hit);
  assign fwd_a    = 2'd0;
  assign fwd_b    = 2'd0;

  logic unused_inputs;
  assign unused_inputs = ^{id_is_branch, ex_is_load, mem_is_load, ex_rs_addr, ex_rt_addr,
                           wb_wr_addr, wb_regwe};
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (id_is_mdu && !data_haz) begin
          mdu_stall = 1'b1;
          if (MDU_CYCLES > 1) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          mdu_stall = 1'b1;
          cnt_d     = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall = data_haz | mdu_stall;

  // Reset holds fetch free-running while ID/EXE is flushed with bubbles.
  assign pc_stall     = rst & stall;
  assign if_id_stall  = rst & stall;
  assign id_exe_pause = ~rst | stall;
  assign fwd_a_sel    = rst ? fwd_a : 2'd0;
  assign fwd_b_sel    = rst ? fwd_b : 2'd0;
  // The cnt==0 BUSY cycle is the issue cycle, so it is not reported as busy.
  assign mdu_busy     = rst & (state_q == ST_BUSY) & (cnt_q != 4'd0);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational hazard/forwarding vectors from a table,
// then hand-written MDU, priority and reset sequences. Expectations follow FORWARDING_EN.
module tb_pipeline_hazard_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] id_rs_addr, id_rt_addr;
  logic       id_rs_used, id_rt_used, id_is_branch, id_is_mdu;
  logic [4:0] ex_rs_addr, ex_rt_addr, ex_wr_addr;
  logic       ex_regwe, ex_is_load;
  logic [4:0] mem_wr_addr;
  logic       mem_regwe, mem_is_load;
  logic [4:0] wb_wr_addr;
  logic       wb_regwe;
  logic       pc_stall, if_id_stall, id_exe_pause, mdu_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  pipeline_hazard_ctrl #(.MDU_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_branch(id_is_branch), .id_is_mdu(id_is_mdu),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_wr_addr(ex_wr_addr),
    .ex_regwe(ex_regwe), .ex_is_load(ex_is_load),
    .mem_wr_addr(mem_wr_addr), .mem_regwe(mem_regwe), .mem_is_load(mem_is_load),
    .wb_wr_addr(wb_wr_addr), .wb_regwe(wb_regwe),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_exe_pause(id_exe_pause),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mdu_busy(mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] id_rs, id_rt;
    logic       rsu, rtu, br;
    logic [4:0] ex_rs, ex_rt, ex_wr;
    logic       ex_we, ex_ld;
    logic [4:0] mem_wr;
    logic       mem_we, mem_ld;
    logic [4:0] wb_wr;
    logic       wb_we;
    logic       stall_f, stall_n;
    logic [1:0] fa, fb;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input int id_rs, input int id_rt, input int rsu, input int rtu,
                              input int br, input int ex_rs, input int ex_rt, input int ex_wr,
                              input int ex_we, input int ex_ld, input int mem_wr,
                              input int mem_we, input int mem_ld, input int wb_wr,
                              input int wb_we, input int sf, input int sn, input int fa,
                              input int fb);
    vec_t v;
    v.id_rs  = 5'(id_rs);  v.id_rt  = 5'(id_rt);
    v.rsu    = 1'(rsu);    v.rtu    = 1'(rtu);    v.br = 1'(br);
    v.ex_rs  = 5'(ex_rs);  v.ex_rt  = 5'(ex_rt);  v.ex_wr = 5'(ex_wr);
    v.ex_we  = 1'(ex_we);  v.ex_ld  = 1'(ex_ld);
    v.mem_wr = 5'(mem_wr); v.mem_we = 1'(mem_we); v.mem_ld = 1'(mem_ld);
    v.wb_wr  = 5'(wb_wr);  v.wb_we  = 1'(wb_we);
    v.stall_f = 1'(sf);    v.stall_n = 1'(sn);
    v.fa     = 2'(fa);     v.fb     = 2'(fb);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs_addr  = v.id_rs;  id_rt_addr = v.id_rt;
    id_rs_used  = v.rsu;    id_rt_used = v.rtu;   id_is_branch = v.br;
    ex_rs_addr  = v.ex_rs;  ex_rt_addr = v.ex_rt; ex_wr_addr   = v.ex_wr;
    ex_regwe    = v.ex_we;  ex_is_load = v.ex_ld;
    mem_wr_addr = v.mem_wr; mem_regwe  = v.mem_we; mem_is_load = v.mem_ld;
    wb_wr_addr  = v.wb_wr;  wb_regwe   = v.wb_we;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_st;
    vec_t z;
    z = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0, 0,0, 0,0);

    //        id_rs,rt,rsu,rtu,br  ex_rs,rt,wr,we,ld  mem_wr,we,ld  wb_wr,we  sf,sn  fa,fb
    tbl.push_back(mk(2,4,1,1,0, 0,0,2,1,1, 0,0,0, 0,0, 1,1, 0,0)); // lw $2 in EXE, use in ID
    tbl.push_back(mk(2,4,1,1,0, 0,0,0,0,0, 2,1,1, 0,0, 0,1, 0,0)); // lw now in MEM
    tbl.push_back(mk(0,0,0,0,0, 2,4,0,0,0, 0,0,0, 2,1, 0,0, 2,0)); // add in EXE, lw in WB
    tbl.push_back(mk(5,0,1,1,1, 0,0,5,1,0, 0,0,0, 0,0, 1,1, 0,0)); // add $5 EXE, beq $5 ID
    tbl.push_back(mk(5,0,1,1,1, 0,0,0,0,0, 5,1,0, 0,0, 0,1, 0,0)); // add $5 in MEM
    tbl.push_back(mk(5,0,1,1,1, 0,0,5,1,1, 0,0,0, 0,0, 1,1, 0,0)); // lw $5 EXE, beq $5
    tbl.push_back(mk(5,0,1,1,1, 0,0,0,0,0, 5,1,1, 0,0, 1,1, 0,0)); // lw $5 MEM, beq $5
    tbl.push_back(mk(5,0,1,1,1, 0,0,0,0,0, 0,0,0, 5,1, 0,0, 0,0)); // lw $5 WB
    tbl.push_back(mk(0,0,0,0,0, 1,1,0,0,0, 1,1,0, 1,1, 0,0, 1,1)); // MEM and WB write $1
    tbl.push_back(mk(0,0,1,1,0, 0,0,0,1,1, 0,1,0, 0,1, 0,0, 0,0)); // everything on $0
    tbl.push_back(mk(0,0,0,0,0, 7,8,0,0,0, 7,0,0, 8,1, 0,0, 0,2)); // MEM regwe off, WB hit on rt
    tbl.push_back(mk(3,0,0,0,0, 0,0,3,1,1, 0,0,0, 0,0, 0,0, 0,0)); // used flag clear
    tbl.push_back(mk(3,0,1,0,0, 0,0,3,0,1, 0,0,0, 0,0, 0,0, 0,0)); // producer regwe clear
    tbl.push_back(mk(3,3,1,1,0, 0,0,3,1,0, 0,0,0, 0,0, 0,1, 0,0)); // add $3 EXE, add $4,$3,$3
    tbl.push_back(mk(3,3,1,1,0, 0,0,0,0,0, 3,1,0, 0,0, 0,1, 0,0)); // add $3 in MEM
    tbl.push_back(mk(3,3,1,1,0, 0,0,0,0,0, 0,0,0, 3,1, 0,0, 0,0)); // add $3 in WB
    tbl.push_back(mk(0,9,0,1,0, 0,0,9,1,1, 0,0,0, 0,0, 1,1, 0,0)); // load-use on rt
    tbl.push_back(mk(0,0,0,0,0, 6,6,0,0,0, 6,1,0, 6,1, 0,0, 1,1)); // MEM beats WB

    // Reset held low with a live hazard and a forwarding match
    rst = 1'b0;
    id_is_mdu = 1'b1;
    drive(mk(2,0,1,0,0, 1,1,2,1,1, 1,1,0, 0,0, 0,0, 0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst pc_stall",     32'(pc_stall),     32'd0);
    check("rst if_id_stall",  32'(if_id_stall),  32'd0);
    check("rst id_exe_pause", 32'(id_exe_pause), 32'd1);
    check("rst fwd_a_sel",    32'(fwd_a_sel),    32'd0);
    check("rst mdu_busy",     32'(mdu_busy),     32'd0);

    next_cycle();
    rst = 1'b1;
    id_is_mdu = 1'b0;
    drive(z);
    @(negedge clk);
    check("idle pc_stall", 32'(pc_stall), 32'd0);

    foreach (tbl[i]) begin
      logic       es;
      logic [1:0] ea, eb;
      next_cycle();
      drive(tbl[i]);
      es = FWD ? tbl[i].stall_f : tbl[i].stall_n;
      ea = FWD ? tbl[i].fa : 2'd0;
      eb = FWD ? tbl[i].fb : 2'd0;
      @(negedge clk);
      check($sformatf("v%0d pc_stall", i),     32'(pc_stall),     32'(es));
      check($sformatf("v%0d if_id_stall", i),  32'(if_id_stall),  32'(es));
      check($sformatf("v%0d id_exe_pause", i), 32'(id_exe_pause), 32'(es));
      check($sformatf("v%0d fwd_a_sel", i),    32'(fwd_a_sel),    32'(ea));
      check($sformatf("v%0d fwd_b_sel", i),    32'(fwd_b_sel),    32'(eb));
      check($sformatf("v%0d mdu_busy", i),     32'(mdu_busy),     32'd0);
    end

    // Single MDU op: 4 stall cycles, busy on cycles 1..3, issues on cycle 4
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      drive(z);
      id_is_mdu = 1'b1;
      @(negedge clk);
      check($sformatf("mdu c%0d stall", c), 32'(pc_stall), 32'((c < 4) ? 1 : 0));
      check($sformatf("mdu c%0d busy", c),  32'(mdu_busy), 32'((c >= 1 && c <= 3) ? 1 : 0));
    end
    next_cycle();
    id_is_mdu = 1'b0;
    @(negedge clk);
    check("mdu after stall", 32'(pc_stall), 32'd0);
    check("mdu after busy",  32'(mdu_busy), 32'd0);

    // Back-to-back MDU ops
    n_st = 0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      id_is_mdu = 1'b1;
      @(negedge clk);
      n_st += int'(pc_stall);
    end
    check("b2b stall count", 32'(n_st), 32'd8);
    check("b2b issue stall", 32'(pc_stall), 32'd0);
    next_cycle();
    id_is_mdu = 1'b0;
    @(negedge clk);
    check("b2b after stall", 32'(pc_stall), 32'd0);

    // MDU op behind a load-use: FSM must wait in IDLE
    next_cycle();
    drive(mk(2,0,1,0,0, 0,0,2,1,1, 0,0,0, 0,0, 0,0, 0,0));
    id_is_mdu = 1'b1;
    @(negedge clk);
    check("prio haz stall", 32'(pc_stall), 32'd1);
    next_cycle();
    drive(z);
    @(negedge clk);
    check("prio idle busy",  32'(mdu_busy), 32'd0);
    check("prio idle stall", 32'(pc_stall), 32'd1);
    next_cycle();
    @(negedge clk);
    check("prio busy1", 32'(mdu_busy), 32'd1);

    // Reset on BUSY cycle 2 aborts the op
    next_cycle();
    rst = 1'b0;
    ex_rs_addr = 5'd1; mem_wr_addr = 5'd1; mem_regwe = 1'b1;
    @(negedge clk);
    check("mid-rst pc_stall",     32'(pc_stall),     32'd0);
    check("mid-rst if_id_stall",  32'(if_id_stall),  32'd0);
    check("mid-rst id_exe_pause", 32'(id_exe_pause), 32'd1);
    check("mid-rst fwd_a_sel",    32'(fwd_a_sel),    32'd0);
    check("mid-rst mdu_busy",     32'(mdu_busy),     32'd0);
    next_cycle();
    rst = 1'b1;
    id_is_mdu = 1'b0;
    drive(z);
    @(negedge clk);
    check("post-rst pc_stall",     32'(pc_stall),     32'd0);
    check("post-rst id_exe_pause", 32'(id_exe_pause), 32'd0);
    check("post-rst mdu_busy",     32'(mdu_busy),     32'd0);
    next_cycle();
    @(negedge clk);
    check("post-rst2 pc_stall", 32'(pc_stall), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
